per_slave_port_arb: RTL and testbench

PER_SLAVE_PORT_ARB -- requirements
Module: per_slave_port_arb

---
 rtl/per_interco_pkg.sv | 32 +++
 rtl/per_id_fifo.sv | 66 ++++++
 rtl/per_slave_port_arb.sv | 150 +++++++++++++++
 tb/tb_per_slave_port_arb.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/per_interco_pkg.sv
// Shared defaults and helpers for the per-slave-port interconnect.
// Holds the default bus widths, the arbiter lock state type and a one-hot
// to index converter sized for up to MAX_PORTS initiators.
package per_interco_pkg;

    localparam int unsigned DEF_N_MASTER        = 16;
    localparam int unsigned DEF_ADDR_WIDTH      = 32;
    localparam int unsigned DEF_DATA_WIDTH      = 32;
    localparam int unsigned DEF_MAX_OUTSTANDING = 2;

    // Upper bound on initiators handled by the index helper.
    localparam int unsigned MAX_PORTS = 64;
    localparam int unsigned MAX_IDX_W = 6;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Converts a one-hot (or all-zero) vector to the index of its set bit.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_PORTS-1:0] onehot);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (onehot[i]) begin
                idx = idx | MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/per_id_fifo.sv
// Small ID FIFO tracking granted requests that still await a response.
// Pointers wrap modulo DEPTH; occupancy is held in $clog2(DEPTH+1) bits.
// Push is ignored when full and pop is ignored when empty.
module per_id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy update; simultaneous push/pop keeps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/per_slave_port_arb.sv
// Per-slave-port arbiter: picks one of N_MASTER initiators, holds the winner
// until the target grants, records the winner's one-hot ID in a FIFO and
// routes each response back to the ID at the FIFO head.
// Build option: PER_RR_PRIORITY_EN selects round-robin arbitration; without
// it the lowest requesting index wins and no RR pointer exists.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ARB_IDLE   | no request held; winner chosen fresh each cycle
// ARB_LOCKED | request presented but not granted; winner frozen until gnt
module per_slave_port_arb
    import per_interco_pkg::*;
#(
    parameter int unsigned N_MASTER        = DEF_N_MASTER,
    parameter int unsigned ID_WIDTH        = N_MASTER,
    parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_MASTER-1:0]            data_req_i,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] data_add_i,
    input  logic [N_MASTER-1:0]            data_wen_i,
    input  logic [N_MASTER*DATA_WIDTH-1:0] data_wdata_i,
    input  logic [N_MASTER*BE_WIDTH-1:0]   data_be_i,
    input  logic [N_MASTER*ID_WIDTH-1:0]   data_ID_i,
    output logic [N_MASTER-1:0]            data_gnt_o,
    output logic [N_MASTER-1:0]            data_r_valid_o,
    output logic [DATA_WIDTH-1:0]          data_r_rdata_o,
    output logic                           data_r_opc_o,
    output logic                           data_req_o,
    output logic [ADDR_WIDTH-1:0]          data_add_o,
    output logic                           data_wen_o,
    output logic [DATA_WIDTH-1:0]          data_wdata_o,
    output logic [BE_WIDTH-1:0]            data_be_o,
    input  logic                           data_gnt_i,
    input  logic                           data_r_valid_i,
    input  logic [DATA_WIDTH-1:0]          data_r_rdata_i,
    input  logic                           data_r_opc_i
);

    localparam int unsigned IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    arb_state_e           r_state;
    arb_state_e           w_state_next;
    logic [IDX_W-1:0]     r_lock_idx;
    logic [IDX_W-1:0]     w_arb_idx;
    logic [IDX_W-1:0]     w_win_idx;
    logic [MAX_PORTS-1:0] w_req_ext;
    logic [MAX_PORTS-1:0] w_req_pick;
    logic [MAX_PORTS-1:0] w_req_low;
    logic                 w_req_active;
    logic                 w_hs;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [ID_WIDTH-1:0]  w_head;
    logic [ID_WIDTH-1:0]  w_push_id;

    assign w_req_ext = MAX_PORTS'(data_req_i);

`ifdef PER_RR_PRIORITY_EN
    logic [IDX_W-1:0]     r_rr_ptr;
    logic [MAX_PORTS-1:0] w_rr_mask;
    logic [MAX_PORTS-1:0] w_req_masked;

    // Requests at or above the pointer take precedence; otherwise wrap around.
    assign w_rr_mask    = ~((MAX_PORTS'(1) << r_rr_ptr) - MAX_PORTS'(1));
    assign w_req_masked = w_req_ext & w_rr_mask;
    assign w_req_pick   = (|w_req_masked) ? w_req_masked : w_req_ext;

    // Pointer moves just past the winner on every handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_hs) begin
            r_rr_ptr <= (w_win_idx == IDX_W'(N_MASTER - 1)) ? '0 : w_win_idx + 1'b1;
        end
    end
`else
    assign w_req_pick = w_req_ext;
`endif

    assign w_req_low = w_req_pick & (~w_req_pick + MAX_PORTS'(1));
    assign w_arb_idx = IDX_W'(onehot_to_idx(w_req_low));
    assign w_win_idx = (r_state == ARB_LOCKED) ? r_lock_idx : w_arb_idx;

    // A full FIFO masks the request even if a pop happens this cycle.
    assign w_req_active = ~rst & ~w_full & ((r_state == ARB_LOCKED) | (|data_req_i));
    assign w_hs         = w_req_active & data_gnt_i;
    assign w_pop        = ~rst & data_r_valid_i & ~w_empty;

    assign data_req_o     = w_req_active;
    assign data_add_o     = data_add_i[w_win_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_wen_o     = data_wen_i[w_win_idx];
    assign data_wdata_o   = data_wdata_i[w_win_idx*DATA_WIDTH +: DATA_WIDTH];
    assign data_be_o      = data_be_i[w_win_idx*BE_WIDTH +: BE_WIDTH];
    assign w_push_id      = data_ID_i[w_win_idx*ID_WIDTH +: ID_WIDTH];
    assign data_r_valid_o = w_pop ? w_head : '0;
    assign data_r_rdata_o = data_r_rdata_i;
    assign data_r_opc_o   = data_r_opc_i;

    // Only the winner sees the target grant.
    always_comb begin
        data_gnt_o = '0;
        if (w_hs) begin
            data_gnt_o[w_win_idx] = 1'b1;
        end
    end

    // Lock state register plus capture of the frozen winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB_IDLE;
            r_lock_idx <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == ARB_IDLE && w_req_active && !data_gnt_i) begin
                r_lock_idx <= w_arb_idx;
            end
        end
    end

    // Lock on an ungranted request, release on the handshake.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE:   if (w_req_active && !data_gnt_i) w_state_next = ARB_LOCKED;
            ARB_LOCKED: if (w_hs) w_state_next = ARB_IDLE;
            default:    w_state_next = ARB_IDLE;
        endcase
    end

    per_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (ID_WIDTH)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_hs),
        .pop   (w_pop),
        .wdata (w_push_id),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

endmodule

// File: tb/tb_per_slave_port_arb.sv
// Self-checking bench for per_slave_port_arb (default parameters).
// Table of single-cycle vectors plus short hand-written sequences; returned
// IDs are checked against a queue of the grants the bench expects.
module tb_per_slave_port_arb;

    localparam int N  = 16;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int IW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    data_req_i;
    logic [N*AW-1:0] data_add_i;
    logic [N-1:0]    data_wen_i;
    logic [N*DW-1:0] data_wdata_i;
    logic [N*BW-1:0] data_be_i;
    logic [N*IW-1:0] data_ID_i;
    logic [N-1:0]    data_gnt_o;
    logic [N-1:0]    data_r_valid_o;
    logic [DW-1:0]   data_r_rdata_o;
    logic            data_r_opc_o;
    logic            data_req_o;
    logic [AW-1:0]   data_add_o;
    logic            data_wen_o;
    logic [DW-1:0]   data_wdata_o;
    logic [BW-1:0]   data_be_o;
    logic            data_gnt_i;
    logic            data_r_valid_i;
    logic [DW-1:0]   data_r_rdata_i;
    logic            data_r_opc_i;

    always #5 clk = ~clk;

    per_slave_port_arb dut (
        .clk            (clk),
        .rst            (rst),
        .data_req_i     (data_req_i),
        .data_add_i     (data_add_i),
        .data_wen_i     (data_wen_i),
        .data_wdata_i   (data_wdata_i),
        .data_be_i      (data_be_i),
        .data_ID_i      (data_ID_i),
        .data_gnt_o     (data_gnt_o),
        .data_r_valid_o (data_r_valid_o),
        .data_r_rdata_o (data_r_rdata_o),
        .data_r_opc_o   (data_r_opc_o),
        .data_req_o     (data_req_o),
        .data_add_o     (data_add_o),
        .data_wen_o     (data_wen_o),
        .data_wdata_o   (data_wdata_o),
        .data_be_o      (data_be_o),
        .data_gnt_i     (data_gnt_i),
        .data_r_valid_i (data_r_valid_i),
        .data_r_rdata_i (data_r_rdata_i),
        .data_r_opc_i   (data_r_opc_i)
    );

    typedef struct {
        logic [N-1:0]  req;
        logic          gnt;
        logic          rv;
        logic [DW-1:0] rdata;
        logic          exp_req;
        int            exp_m;
    } vec_t;

    vec_t         tbl[13];
    int           n_vec = 0;
    int           n_err = 0;
    logic [N-1:0] sb_q[$];

    function automatic logic [AW-1:0] addr_of(input int m);
        return 32'h1000_0000 + AW'(m * 16);
    endfunction

    function automatic logic [DW-1:0] wdata_of(input int m);
        return 32'hD000_0000 | DW'(m);
    endfunction

    function automatic logic [BW-1:0] be_of(input int m);
        return (m % 2 == 0) ? 4'hF : 4'h3;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] req, input logic gnt, input logic rv,
                                input logic [DW-1:0] rdata, input logic exp_req, input int m);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata;
        v.exp_req = exp_req; v.exp_m = m;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        logic [N-1:0] exp_gnt;
        logic [N-1:0] exp_rv;
        data_req_i     = v.req;
        data_gnt_i     = v.gnt;
        data_r_valid_i = v.rv;
        data_r_rdata_i = v.rdata;
        data_r_opc_i   = v.rdata[0];
        exp_gnt = (v.exp_req && v.gnt) ? (N'(1) << v.exp_m) : '0;
        exp_rv  = (v.rv && sb_q.size() > 0) ? sb_q[0] : '0;
        @(negedge clk);
        chk({tag, " req_o"},   64'(data_req_o),     64'(v.exp_req));
        chk({tag, " gnt_o"},   64'(data_gnt_o),     64'(exp_gnt));
        chk({tag, " rvalid"},  64'(data_r_valid_o), 64'(exp_rv));
        chk({tag, " rdata"},   64'(data_r_rdata_o), 64'(v.rdata));
        chk({tag, " opc"},     64'(data_r_opc_o),   64'(v.rdata[0]));
        if (v.exp_req) begin
            chk({tag, " add_o"},   64'(data_add_o),   64'(addr_of(v.exp_m)));
            chk({tag, " wdata_o"}, 64'(data_wdata_o), 64'(wdata_of(v.exp_m)));
            chk({tag, " be_o"},    64'(data_be_o),    64'(be_of(v.exp_m)));
            chk({tag, " wen_o"},   64'(data_wen_o),   64'(v.exp_m % 2));
        end
        if (v.rv && sb_q.size() > 0) void'(sb_q.pop_front());
        if (exp_gnt != '0) sb_q.push_back(exp_gnt);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst            = 1'b1;
        data_req_i     = '1;
        data_gnt_i     = 1'b1;
        data_r_valid_i = 1'b1;
        @(negedge clk);
        chk({tag, " rst req_o"},  64'(data_req_o),     64'd0);
        chk({tag, " rst gnt_o"},  64'(data_gnt_o),     64'd0);
        chk({tag, " rst rvalid"}, 64'(data_r_valid_o), 64'd0);
        @(posedge clk);
        #1;
        rst            = 1'b0;
        data_req_i     = '0;
        data_gnt_i     = 1'b0;
        data_r_valid_i = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        int exp_m026[4];
        rst            = 1'b1;
        data_req_i     = '0;
        data_gnt_i     = 1'b0;
        data_r_valid_i = 1'b0;
        data_r_rdata_i = '0;
        data_r_opc_i   = 1'b0;
        for (int m = 0; m < N; m++) begin
            data_add_i[m*AW +: AW]   = addr_of(m);
            data_wdata_i[m*DW +: DW] = wdata_of(m);
            data_be_i[m*BW +: BW]    = be_of(m);
            data_wen_i[m]            = (m % 2 == 1);
            data_ID_i[m*IW +: IW]    = IW'(1) << m;
        end

        // Multi-request entries are chosen so fixed priority and RR agree.
        tbl[0]  = mk(16'h0000, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 0);
        tbl[1]  = mk(16'h0004, 1'b1, 1'b0, 32'h0000_0001, 1'b1, 2);
        tbl[2]  = mk(16'h0080, 1'b1, 1'b0, 32'h0000_0002, 1'b1, 7);
        tbl[3]  = mk(16'h0010, 1'b1, 1'b0, 32'h0000_0003, 1'b0, 4);
        tbl[4]  = mk(16'h0010, 1'b1, 1'b1, 32'hA5A5_A5A5, 1'b0, 4);
        tbl[5]  = mk(16'h0010, 1'b1, 1'b1, 32'h5A5A_5A5A, 1'b1, 4);
        tbl[6]  = mk(16'h0000, 1'b0, 1'b1, 32'h1234_5677, 1'b0, 0);
        tbl[7]  = mk(16'h0000, 1'b0, 1'b1, 32'hFFFF_0000, 1'b0, 0);
        tbl[8]  = mk(16'h1200, 1'b1, 1'b0, 32'h0000_0009, 1'b1, 9);
        tbl[9]  = mk(16'h4800, 1'b0, 1'b0, 32'h0000_000B, 1'b1, 11);
        tbl[10] = mk(16'h0801, 1'b1, 1'b0, 32'h0000_000C, 1'b1, 11);
        tbl[11] = mk(16'h0000, 1'b0, 1'b1, 32'hCAFE_0001, 1'b0, 0);
        tbl[12] = mk(16'h0000, 1'b0, 1'b1, 32'hCAFE_0002, 1'b0, 0);

        @(posedge clk);
        #1;
        do_reset("init");
        for (int i = 0; i < 13; i++) begin
            apply(tbl[i], $sformatf("v%0d", i));
        end

        // Winner held while ungranted despite a lower index arriving.
        apply(mk(16'h0020, 1'b0, 1'b0, 32'h0, 1'b1, 5), "lock c1");
        apply(mk(16'h0022, 1'b0, 1'b0, 32'h0, 1'b1, 5), "lock c2");
        apply(mk(16'h0022, 1'b0, 1'b0, 32'h0, 1'b1, 5), "lock c3");
        apply(mk(16'h0022, 1'b1, 1'b0, 32'h0, 1'b1, 5), "lock c4");
        apply(mk(16'h0000, 1'b0, 1'b1, 32'h0, 1'b0, 0), "lock rsp");

        // Masters 0 and 3 contend with continuous grant and response.
`ifdef PER_RR_PRIORITY_EN
        exp_m026 = '{0, 3, 0, 3};
`else
        exp_m026 = '{0, 0, 0, 0};
`endif
        do_reset("arb");
        for (int i = 0; i < 4; i++) begin
            apply(mk(16'h0009, 1'b1, 1'b1, 32'h0000_0100, 1'b1, exp_m026[i]), $sformatf("arb g%0d", i));
        end
        apply(mk(16'h0000, 1'b0, 1'b1, 32'h0, 1'b0, 0), "arb drain");

        // Reset with one ID outstanding discards it.
        apply(mk(16'h0040, 1'b1, 1'b0, 32'h0, 1'b1, 6), "mid hs");
        do_reset("mid");
        apply(mk(16'h0000, 1'b0, 1'b1, 32'h0, 1'b0, 0), "mid late rsp");
        apply(mk(16'h0002, 1'b1, 1'b0, 32'h0, 1'b1, 1), "mid new hs");
        apply(mk(16'h0000, 1'b0, 1'b1, 32'h0, 1'b0, 0), "mid new rsp");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
